// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified instruction/data memory between the
//   fetch port (if_*) and the data port (d_*). Each access runs through
//   IDLE -> ISSUE -> [WAIT] -> RESP. The requester receives a one-cycle done
//   pulse in RESP. The data port has priority. A streak counter lets fetch win
//   after STARVE_LIMIT consecutive data grants that were made while fetch was
//   waiting.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   if_req/addr         : fetch request, held until if_done_o
//   if_rdata/done       : fetched word (held) and completion pulse
//   d_req/we/size/addr/wdata : data request, held until d_done_o
//   d_rdata/done        : load data (held) and completion pulse
//   mem_*               : memory side; mem_rdata_i is valid LATENCY cycles
//                         after the mem_en_o cycle
//   busy_o              : FSM not in IDLE
//   if/d_wait_cnt_o     : wait-cycle counters. They are present only when the
//                         macro MEM_PORT_ARBITER_PERF_EN is defined. Otherwise
//                         both read as 0.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_i,
  input  logic [ADDRESS_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0]    if_rdata_o,
  output logic                     if_done_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [1:0]               d_size_i,
  input  logic [ADDRESS_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0]    d_wdata_i,
  output logic [DATA_WIDTH-1:0]    d_rdata_o,
  output logic                     d_done_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [1:0]               mem_size_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic                     busy_o,
  output logic [15:0]              if_wait_cnt_o,
  output logic [15:0]              d_wait_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nx;

  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [1:0]               lat_size;
  logic                     lat_we;
  logic                     lat_d;      // 1 = data port owns the access
  logic [3:0]               streak;
  logic [3:0]               lat_cnt;
  logic                     any_req;
  logic                     grant_d;

  assign any_req = if_req_i | d_req_i;
  // Fetch wins only on a tie once the streak has reached the limit.
  assign grant_d = d_req_i & (~if_req_i | (streak != 4'(STARVE_LIMIT)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = lat_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs. The mem_* address, size and wdata come straight from the latched
  // fields, so they hold their values between accesses.
  always_comb begin
    mem_en_o  = (state == ISSUE);
    mem_we_o  = (state == ISSUE) & lat_we;
    if_done_o = (state == RESP) & ~lat_d;
    d_done_o  = (state == RESP) & lat_d;
    busy_o    = (state != IDLE);
  end

  assign mem_addr_o  = lat_addr;
  assign mem_size_o  = lat_size;
  assign mem_wdata_o = lat_wdata;

  // Request latch, streak counter, latency counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      lat_we     <= 1'b0;
      lat_d      <= 1'b0;
      streak     <= '0;
      lat_cnt    <= '0;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          lat_d <= grant_d;
          if (grant_d) begin
            lat_addr  <= d_addr_i;
            lat_wdata <= d_wdata_i;
            lat_size  <= d_size_i;
            lat_we    <= d_we_i;
            streak    <= if_req_i ? streak + 4'd1 : 4'd0;
          end else begin
            // Fetch is always a word read.
            lat_addr  <= if_addr_i;
            lat_wdata <= '0;
            lat_size  <= 2'b10;
            lat_we    <= 1'b0;
            streak    <= 4'd0;
          end
        end
        ISSUE: lat_cnt <= 4'(LATENCY - 1);
        WAIT: begin
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
          else if (lat_d)      d_rdata_o  <= mem_rdata_i;
          else                 if_rdata_o <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] if_wait_cnt, d_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_cnt <= '0;
      d_wait_cnt  <= '0;
    end else begin
      if (if_req_i && !if_done_o && if_wait_cnt != 16'hFFFF) if_wait_cnt <= if_wait_cnt + 16'd1;
      if (d_req_i && !d_done_o && d_wait_cnt != 16'hFFFF)    d_wait_cnt  <= d_wait_cnt + 16'd1;
    end
  end

  assign if_wait_cnt_o = if_wait_cnt;
  assign d_wait_cnt_o  = d_wait_cnt;
`else
  assign if_wait_cnt_o = 16'd0;
  assign d_wait_cnt_o  = 16'd0;
`endif

endmodule
